// File: rtl/chan_readout_sched_if.sv
`timescale 1ns/1ps
// Stream link from the readout scheduler toward frame_header.
// Latency: none, plain wires.
// Backpressure: master holds data/vld until vld&rdy.
// Signals: data (32b word), vld (word present), rdy (sink accepts).
interface chan_readout_sched_if;
    logic [31:0] data;
    logic        vld;
    logic        rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/chan_readout_sched.sv
`timescale 1ns/1ps
// Readout scheduler: walks enabled channels 0..3, emits header + buffer words per channel.
// Latency: i_start at edge T -> header valid at T+2; data streams 1 word/clk after header.
// Backpressure: strm.rdy stalls the stream; read-ahead + 2-entry skid never drops/repeats.
// Ports: clk, rst (sync, active-high); i_start/i_vchn/i_ch_en/i_len_0..3 frame request;
//        i_rd_data_0..3, o_rd_vchn, o_rd_addr buffer read port (1-clk read latency);
//        strm (master) output stream; o_busy, o_done, o_overrun, o_frame_words status.
// Optional: define SCHED_TRAILER_EN to append an XOR trailer word after the last channel.
module chan_readout_sched #(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] HDR_TAG = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [1:0]           i_vchn,
    input  logic [3:0]           i_ch_en,
    input  logic [7:0]           i_len_0,
    input  logic [7:0]           i_len_1,
    input  logic [7:0]           i_len_2,
    input  logic [7:0]           i_len_3,
    input  logic [31:0]          i_rd_data_0,
    input  logic [31:0]          i_rd_data_1,
    input  logic [31:0]          i_rd_data_2,
    input  logic [31:0]          i_rd_data_3,
    output logic [1:0]           o_rd_vchn,
    output logic [ADDR_W-1:0]    o_rd_addr,
    chan_readout_sched_if.master strm,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun,
    output logic [15:0]          o_frame_words
);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int MAX_LEN = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_HDR,
        S_DATA,
`ifdef SCHED_TRAILER_EN
        S_TRL,
`endif
        S_END
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] len);
        if (int'(len) > MAX_LEN) return CNT_W'(MAX_LEN);
        return CNT_W'(len);
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         ch_q, ch_d;          // 3 bits so "past channel 3" is representable
    logic [1:0]         vchn_q;
    logic [3:0]         mask_q;
    logic [CNT_W-1:0]   len_q [4];
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]   iss_q, iss_d;        // reads issued in this channel
    logic [CNT_W-1:0]   popd_q, popd_d;      // words accepted in this channel
    logic               pend_q, pend_d;      // read issued last clk, data on i_rd_data now
    logic [31:0]        skid_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         cnt_q;
    logic [15:0]        fw_q;
    logic               ovr_q;
`ifdef SCHED_TRAILER_EN
    logic [31:0]        xor_q;
`endif

    logic               vld_c, done_c, push_c, pop_c, skid_pop_c, found, accept_c;
    logic [31:0]        data_c, rd_sel, hdr_word;
    logic [CNT_W-1:0]   cur_len;
    int                 occ;

    assign cur_len  = len_q[ch_q[1:0]];
    assign hdr_word = {HDR_TAG, ch_q[1:0], vchn_q, 4'b0, 8'b0, 8'(cur_len)};

    always_comb begin
        case (ch_q[1:0])
            2'd0:    rd_sel = i_rd_data_0;
            2'd1:    rd_sel = i_rd_data_1;
            2'd2:    rd_sel = i_rd_data_2;
            default: rd_sel = i_rd_data_3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rd_addr_d = rd_addr_q;
        iss_d     = iss_q;
        popd_d    = popd_q;
        pend_d    = 1'b0;
        vld_c     = 1'b0;
        data_c    = '0;
        done_c    = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        found     = 1'b0;
        occ       = 0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_SEL;
                    ch_d    = '0;
                end
            end
            S_SEL: begin
                rd_addr_d = '0;
                iss_d     = '0;
                popd_d    = '0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && i >= int'(ch_q) && mask_q[i]) begin
                        found = 1'b1;
                        ch_d  = 3'(i);
                    end
                end
`ifdef SCHED_TRAILER_EN
                state_d = found ? S_HDR : S_TRL;
`else
                state_d = found ? S_HDR : S_END;
`endif
            end
            S_HDR: begin
                vld_c  = 1'b1;
                data_c = hdr_word;
                if (strm.rdy) begin
                    if (cur_len == '0) begin
                        ch_d    = ch_q + 3'd1;
                        state_d = S_SEL;
                    end else begin
                        // address 0 is on the bus during HDR: its data lands in the
                        // first DATA cycle, so word 0 follows the header with no bubble
                        state_d = S_DATA;
                        pend_d  = 1'b1;
                        iss_d   = CNT_W'(1);
                        if (cur_len > CNT_W'(1)) rd_addr_d = ADDR_W'(1);
                    end
                end
            end
            S_DATA: begin
                // skid head first; otherwise bypass the RAM word arriving this clk
                vld_c  = (cnt_q != 2'd0) || pend_q;
                data_c = (cnt_q != 2'd0) ? skid_q[rd_ptr_q] : rd_sel;
                pop_c  = vld_c && strm.rdy;
                push_c = pend_q && !((cnt_q == 2'd0) && pop_c);
                // issue another read only if the skid can absorb it next clk
                occ = int'(cnt_q) + int'(pend_q) - int'(pop_c);
                if ((iss_q < cur_len) && (occ < 2)) begin
                    pend_d = 1'b1;
                    iss_d  = iss_q + CNT_W'(1);
                    // hold the address on the last word so it never wraps
                    if (iss_q + CNT_W'(1) < cur_len) rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
                if (pop_c) begin
                    popd_d = popd_q + CNT_W'(1);
                    if (popd_q + CNT_W'(1) == cur_len) begin
                        state_d   = S_SEL;
                        ch_d      = ch_q + 3'd1;
                        rd_addr_d = '0;
                        iss_d     = '0;
                        popd_d    = '0;
                    end
                end
            end
`ifdef SCHED_TRAILER_EN
            S_TRL: begin
                vld_c  = 1'b1;
                data_c = xor_q;
                if (strm.rdy) state_d = S_END;
            end
`endif
            S_END: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign skid_pop_c = pop_c && (cnt_q != 2'd0);
    assign accept_c   = vld_c && strm.rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            vchn_q    <= '0;
            mask_q    <= '0;
            for (int i = 0; i < 4; i++) len_q[i] <= '0;
            rd_addr_q <= '0;
            iss_q     <= '0;
            popd_q    <= '0;
            pend_q    <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cnt_q     <= '0;
            fw_q      <= '0;
            ovr_q     <= 1'b0;
`ifdef SCHED_TRAILER_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rd_addr_q <= rd_addr_d;
            iss_q     <= iss_d;
            popd_q    <= popd_d;
            pend_q    <= pend_d;
            ovr_q     <= i_start && (state_q != S_IDLE);
            if (state_q == S_IDLE && i_start) begin
                vchn_q   <= i_vchn;
                mask_q   <= i_ch_en;
                len_q[0] <= clamp_len(i_len_0);
                len_q[1] <= clamp_len(i_len_1);
                len_q[2] <= clamp_len(i_len_2);
                len_q[3] <= clamp_len(i_len_3);
                fw_q     <= '0;
`ifdef SCHED_TRAILER_EN
                xor_q    <= '0;
`endif
            end else if (accept_c) begin
                if (fw_q != 16'hFFFF) fw_q <= fw_q + 16'd1;
`ifdef SCHED_TRAILER_EN
                xor_q <= xor_q ^ data_c;
`endif
            end
            if (push_c) begin
                skid_q[wr_ptr_q] <= rd_sel;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (skid_pop_c) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push_c} - {1'b0, skid_pop_c};
        end
    end

    assign strm.data     = data_c;
    assign strm.vld      = vld_c;
    assign o_rd_vchn     = vchn_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = done_c;
    assign o_overrun     = ovr_q;
    assign o_frame_words = fw_q;
endmodule
